serial_word_tx: RTL and testbench

Parallel-to-serial transmitter that produces the LSB-first bit stream consumed by the team's bit-serial two's-complement stage. It accepts a WIDTH-bit word through a valid/ready handshake. Before the first bit of every word it issues a one-cycle clear strobe, so the downstream serial stage starts each word from a known state. It then shifts the word out one bit per clock with framing strobes.

---
 rtl/serial_word_tx.sv | 132 +++++++++++++
 tb/tb_serial_word_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - LSB-first parallel-to-serial word transmitter with clear and framing strobes
//
// Accepts a WIDTH-bit word on a valid/ready handshake, issues a one-cycle
// clear strobe, then shifts the word out LSB first, one bit per clock,
// followed by GAP idle cycles before the next word can be accepted.
//
// Ports:
//   t_clk       clock, all state updates on the rising edge
//   r           asynchronous active-high reset
//   load_valid  producer has a word on load_data
//   load_data   word to transmit, captured on the handshake edge
//   load_ready  block can accept a word (high only while idle)
//   sclr        one-cycle clear strobe to the downstream serial stage, precedes bit 0
//   sout        serial data, LSB first
//   sval        sout carries a valid bit this cycle
//   sfirst      high with bit 0 of a word
//   slast       high with bit WIDTH-1 (the sign bit) of a word
module serial_word_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sclr,
    output logic             sout,
    output logic             sval,
    output logic             sfirst,
    output logic             slast
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [7:0]       gcnt;

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            shreg <= '0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        shreg <= load_data;
                    end
                end
                ST_PREP: begin
                    cnt <= '0;
                end
                ST_SHIFT: begin
                    shreg <= shreg >> 1;
                    gcnt  <= '0;
                    // Hold at the last index rather than wrapping; PREP re-arms it.
                    if (cnt != BIT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    gcnt <= gcnt + 8'd1;
                end
                default: begin
                    shreg <= shreg;
                end
            endcase
        end
    end

    // Outputs decode only from state and registers, never from inputs.
    always_comb begin
        state_d    = state;
        load_ready = 1'b0;
        sclr       = 1'b0;
        sout       = 1'b0;
        sval       = 1'b0;
        sfirst     = 1'b0;
        slast      = 1'b0;
        case (state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                sclr    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sval   = 1'b1;
                sout   = shreg[0];
                sfirst = (cnt == '0);
                slast  = (cnt == BIT_LAST);
                if (cnt == BIT_LAST) begin
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx (GAP=0 and GAP=3 instances)
module tb_serial_word_tx;

    localparam int W = 8;

    typedef struct packed {
        logic ready;
        logic sclr;
        logic sout;
        logic sval;
        logic sfirst;
        logic slast;
    } obs_t;

    logic t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge t_clk) cyc <= cyc + 1;

    logic         r;
    logic [1:0]   lv;
    logic [W-1:0] ld [2];
    wire  [1:0]   rdy, sclr_w, sout_w, sval_w, sfirst_w, slast_w;

    serial_word_tx #(.WIDTH(W), .GAP(0)) u_dut0 (
        .t_clk(t_clk), .r(r), .load_valid(lv[0]), .load_data(ld[0]),
        .load_ready(rdy[0]), .sclr(sclr_w[0]), .sout(sout_w[0]),
        .sval(sval_w[0]), .sfirst(sfirst_w[0]), .slast(slast_w[0])
    );

    serial_word_tx #(.WIDTH(W), .GAP(3)) u_dut1 (
        .t_clk(t_clk), .r(r), .load_valid(lv[1]), .load_data(ld[1]),
        .load_ready(rdy[1]), .sclr(sclr_w[1]), .sout(sout_w[1]),
        .sval(sval_w[1]), .sfirst(sfirst_w[1]), .slast(slast_w[1])
    );

    // Downstream bit-serial two's-complement stage fed by dut0.
    logic tc_seen;
    logic tc_out;
    always @(posedge t_clk or posedge r) begin
        if (r)                          tc_seen <= 1'b0;
        else if (sclr_w[0])             tc_seen <= 1'b0;
        else if (sval_w[0] && sout_w[0]) tc_seen <= 1'b1;
    end
    assign tc_out = sout_w[0] ^ tc_seen;

    // Model: each accepted word occupies one sclr cycle, W bit cycles and GAP
    // quiet cycles, counted from the cycle after its handshake edge.
    logic         busy    [2];
    int           hs_cyc  [2];
    int           hs_cnt  [2];
    logic [W-1:0] hs_word [2];

    function automatic int gap_of(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    function automatic logic model_ready(input int g, input int c);
        return !busy[g] || (c - hs_cyc[g] > W + gap_of(g));
    endfunction

    always @(posedge t_clk or posedge r) begin
        if (r) begin
            for (int g = 0; g < 2; g++) busy[g] <= 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (model_ready(g, cyc) && lv[g]) begin
                    busy[g]    <= 1'b1;
                    hs_cyc[g]  <= cyc + 1;
                    hs_word[g] <= ld[g];
                    hs_cnt[g]  <= hs_cnt[g] + 1;
                end
            end
        end
    end

    function automatic obs_t expect_obs(input int g, input int c);
        obs_t e;
        int   off;
        e = '0;
        off = c - hs_cyc[g];
        if (model_ready(g, c)) begin
            e.ready = 1'b1;
        end else if (off == 0) begin
            e.sclr = 1'b1;
        end else if (off <= W) begin
            e.sval   = 1'b1;
            e.sout   = hs_word[g][off-1];
            e.sfirst = (off == 1);
            e.slast  = (off == W);
        end
        return e;
    endfunction

    function automatic obs_t get_obs(input int g);
        return {rdy[g], sclr_w[g], sout_w[g], sval_w[g], sfirst_w[g], slast_w[g]};
    endfunction

    // Per-cycle compare plus capture of streams and strobe timing.
    int           sclr_cyc [2], first_cyc [2], last_cyc [2], ready_cyc [2];
    logic         prev_rdy [2];
    logic [W-1:0] acc [2];
    logic [W-1:0] acc_tc;
    int           bi  [2];
    logic [W-1:0] hist [2][16];
    logic [W-1:0] hist_tc [16];
    int           nw [2];

    always @(negedge t_clk) begin
        for (int g = 0; g < 2; g++) begin
            obs_t o, e;
            o = get_obs(g);
            e = expect_obs(g, cyc);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL cycle_compare dut%0d cyc %0d: got %b expected %b", g, cyc, o, e);
            end
            if (o.sclr)   sclr_cyc[g]  = cyc;
            if (o.sfirst) first_cyc[g] = cyc;
            if (o.slast)  last_cyc[g]  = cyc;
            if (o.ready && !prev_rdy[g]) ready_cyc[g] = cyc;
            prev_rdy[g] = o.ready;
            if (o.sval) begin
                if (o.sfirst) begin
                    acc[g] = '0;
                    bi[g]  = 0;
                end
                if (bi[g] < W) begin
                    acc[g][bi[g]] = o.sout;
                    if (g == 0) acc_tc[bi[g]] = tc_out;
                end
                bi[g]++;
                if (o.slast) begin
                    hist[g][nw[g] % 16] = acc[g];
                    if (g == 0) hist_tc[nw[g] % 16] = acc_tc;
                    nw[g]++;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_hs(input int g, output int k);
        int n0;
        n0 = hs_cnt[g];
        k  = -1000;
        for (int i = 0; i < 40; i++) begin
            @(negedge t_clk);
            if (hs_cnt[g] != n0) begin
                k = hs_cyc[g];
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL handshake_timeout dut%0d: got none expected within 40 cycles", g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, n0;
        for (int g = 0; g < 2; g++) begin
            busy[g] = 1'b0; hs_cyc[g] = 0; hs_cnt[g] = 0; hs_word[g] = '0;
            nw[g] = 0; bi[g] = 0; acc[g] = '0; prev_rdy[g] = 1'b1;
            sclr_cyc[g] = -1; first_cyc[g] = -1; last_cyc[g] = -1; ready_cyc[g] = -1;
        end
        acc_tc = '0;
        r  = 1'b1;
        lv = 2'b00;
        ld[0] = '0;
        ld[1] = '0;
        repeat (2) @(negedge t_clk);
        check("reset_outputs_dut0", get_obs(0), 6'b100000);
        check("reset_outputs_dut1", get_obs(1), 6'b100000);
        r = 1'b0;
        @(negedge t_clk);

        // Single word 0xB4: latency and bit order.
        lv[0] = 1'b1; ld[0] = 8'hB4; n0 = nw[0];
        wait_hs(0, k);
        lv[0] = 1'b0;
        repeat (12) @(negedge t_clk);
        check("b4_sclr_cycle",  sclr_cyc[0]  - k, 0);
        check("b4_sfirst_cycle", first_cyc[0] - k, 1);
        check("b4_slast_cycle", last_cyc[0]  - k, 8);
        check("b4_ready_cycle", ready_cyc[0] - k, 9);
        check("b4_stream",      hist[0][n0 % 16], 8'hB4);

        // Back-to-back 0x01, 0x80 with load_valid held.
        lv[0] = 1'b1; ld[0] = 8'h01; n0 = nw[0];
        wait_hs(0, k);
        ld[0] = 8'h80;
        wait_hs(0, k2);
        lv[0] = 1'b0;
        repeat (12) @(negedge t_clk);
        check("b2b_spacing",  k2 - k, 10);
        check("b2b_word0",    hist[0][n0 % 16], 8'h01);
        check("b2b_word1",    hist[0][(n0 + 1) % 16], 8'h80);

        // GAP=3 instance, 0xFF.
        lv[1] = 1'b1; ld[1] = 8'hFF; n0 = nw[1];
        wait_hs(1, k);
        lv[1] = 1'b0;
        repeat (15) @(negedge t_clk);
        check("gap3_slast_cycle", last_cyc[1]  - k, 8);
        check("gap3_ready_cycle", ready_cyc[1] - k, 12);
        check("gap3_stream",      hist[1][n0 % 16], 8'hFF);

        // load_data toggling during the word has no effect; next capture at the idle edge.
        lv[0] = 1'b1; ld[0] = 8'h3C; n0 = nw[0];
        wait_hs(0, k);
        for (int i = 0; i < 9; i++) begin
            ld[0] = 8'($urandom);
            @(negedge t_clk);
        end
        ld[0] = 8'h5A;
        wait_hs(0, k2);
        lv[0] = 1'b0;
        repeat (12) @(negedge t_clk);
        check("hold_capture_edge", k2 - k, 10);
        check("hold_word0",        hist[0][n0 % 16], 8'h3C);
        check("hold_word1",        hist[0][(n0 + 1) % 16], 8'h5A);

        // Two's-complement chain: 0x06 -> 0xFA, 0x00 -> 0x00.
        lv[0] = 1'b1; ld[0] = 8'h06; n0 = nw[0];
        wait_hs(0, k);
        ld[0] = 8'h00;
        wait_hs(0, k2);
        lv[0] = 1'b0;
        repeat (12) @(negedge t_clk);
        check("twos_06", hist_tc[n0 % 16], 8'hFA);
        check("twos_00", hist_tc[(n0 + 1) % 16], 8'h00);

        // Reset mid-SHIFT: outputs drop at once; new load accepted on the first edge after release.
        lv[0] = 1'b1; ld[0] = 8'hA5;
        wait_hs(0, k);
        lv[0] = 1'b0;
        repeat (3) @(negedge t_clk);
        check("pre_reset_in_shift", get_obs(0).sval, 1);
        #2 r = 1'b1;
        #1;
        check("async_reset_dut0", get_obs(0), 6'b100000);
        @(negedge t_clk);
        n0 = nw[0];
        r = 1'b0; lv[0] = 1'b1; ld[0] = 8'h33;
        k2 = cyc;
        wait_hs(0, k);
        lv[0] = 1'b0;
        repeat (12) @(negedge t_clk);
        check("post_reset_first_edge", k - k2, 1);
        check("post_reset_words",      nw[0] - n0, 1);
        check("post_reset_stream",     hist[0][n0 % 16], 8'h33);

        repeat (3) @(negedge t_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
